dedicated_datapath: RTL and testbench
=====================================

DEDICATED_DATAPATH -- requirements
Module: dedicated_datapath

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the register and output data width in bits.
REQ-002 Parameter LIMIT, default 10, SHALL set the loop-bound constant used by the le comparison.
REQ-003 clk  input  1  system clock; all state SHALL update on its rising edge only.
REQ-004 rst_n  input  1  reset; one clock, asynchronous assert, active-low.
REQ-005 MuxSel  input  1  write-data select: 1 = constant 1, 0 = adder result.
REQ-006 raddr1  input  4  register-file read port 1 address.
REQ-007 raddr2  input  4  register-file read port 2 address.
REQ-008 waddr  input  4  register-file write address.
REQ-009 wEn  input  1  register-file write enable.
REQ-010 outBuf  input  1  output-buffer load strobe.
REQ-011 le  output  1  status to controller: rdata1 <= LIMIT.
REQ-012 outPort  output  DATA_W  registered result.
REQ-013 outValid  output  1  sticky flag: outPort has been loaded at least once.
REQ-014 ovf  output  1  sticky flag: a committed adder write wrapped.

Function
REQ-015 The register file SHALL hold 16 entries of DATA_W bits, R0..R15.
REQ-016 R0 SHALL always read 0; writes to waddr=0 SHALL be discarded and SHALL NOT set ovf.
REQ-017 Both reads SHALL be combinational: rdata1 = R[raddr1], rdata2 = R[raddr2], independently addressed.
REQ-018 Adder SHALL compute rdata1 + rdata2 modulo 2^DATA_W; the carry-out SHALL be retained internally.
REQ-019 Write data SHALL be 1 (zero-extended) when MuxSel=1, else the adder sum.
REQ-020 On a rising clk with wEn=1 and waddr!=0, R[waddr] SHALL take the write data; with wEn=0 the file SHALL hold.
REQ-021 Read-during-write to the same address SHALL return the old value within the cycle; the new value SHALL be visible from the next cycle.
REQ-022 le SHALL be combinational from rdata1, unsigned compare, so the controller can branch in the same cycle.
REQ-023 le SHALL be 1 exactly when rdata1 <= LIMIT, including rdata1 == LIMIT.
REQ-024 On a rising clk with outBuf=1, outPort SHALL load rdata2 and outValid SHALL set; with outBuf=0, outPort SHALL hold.
REQ-025 outBuf and wEn asserted in the same cycle SHALL both take effect; outPort SHALL capture the pre-write rdata2.
REQ-026 ovf SHALL set on a clock where wEn=1, MuxSel=0, waddr!=0 and the adder carry-out = 1.
REQ-027 ovf and outValid SHALL clear only on reset.
REQ-028 Control inputs SHALL be treated as don't-care when their enables are low; X on an unused address SHALL NOT corrupt state.

Reset
REQ-029 While rst_n=0, R1..R15, outPort, outValid and ovf SHALL be 0, asynchronously.
REQ-030 le SHALL then reflect the zeroed registers, i.e. le = 1 for LIMIT >= 0.
REQ-031 Reset asserted mid-loop SHALL abort any pending write; no partial update SHALL survive release.
REQ-032 Release SHALL take effect at the first rising clk with rst_n=1.

Structure
REQ-033 Package dp_pkg SHALL hold DATA_W, ADDR_W=4, NREG=16 and LIMIT defaults, shared with ControllerUnit.
REQ-034 Sub-module register_file (2 read ports, 1 write port, R0 hardwired zero) SHALL be instantiated once.
REQ-035 Mux, adder, comparator and output register SHALL live at the top level.

Verification
REQ-036 Reset, then probe reads: raddr1=5, raddr2=0 -> rdata zero, le=1, outPort=0, outValid=0, ovf=0.
REQ-037 MuxSel=1, wEn=1, waddr=1, then MuxSel=0, raddr1=1, raddr2=1, waddr=2 -> R2=2; raddr1=2 gives le=1.
REQ-038 Load R2=10 then R2=11 via additions -> le=1 at 10, le=0 at 11 (boundary).
REQ-039 Write to waddr=0 with sum 0x05 -> R0 still reads 0; ovf unchanged.
REQ-040 R1=0x80, R2=0x80, add into R3 -> R3=0x00, ovf=1 and sticky for 3 idle cycles.
REQ-041 Full closed loop with ControllerUnit, 1..10 accumulation -> outPort=55, outValid=1.
REQ-042 Same closed loop with rst_n pulsed mid-loop -> all state 0, then the rerun again yields 55.

Source files
------------

// File: rtl/dp_pkg.sv
// Shared constants and types for the dedicated datapath and its controller.
// Widths, register count and loop bound live here so both sides agree.
package dp_pkg;

    localparam int DP_DATA_W = 8;
    localparam int DP_ADDR_W = 4;
    localparam int DP_NREG   = 16;
    localparam int DP_LIMIT  = 10;

    typedef enum logic {
        WSEL_SUM = 1'b0,
        WSEL_ONE = 1'b1
    } wsel_e;

    // Unsigned "value <= bound" at 32 bits so any DATA_W up to 32 works.
    function automatic logic le_bound(
        input logic [31:0] value,
        input logic [31:0] bound
    );
        return value <= bound;
    endfunction

endpackage

// File: rtl/dedicated_datapath_register_file.sv
// 16-entry register file: two combinational read ports, one write port.
// Entry 0 is hardwired to zero; writes to it are dropped.
module register_file
    import dp_pkg::*;
#(
    parameter int DATA_W = DP_DATA_W,
    parameter int ADDR_W = DP_ADDR_W,
    parameter int NREG   = DP_NREG
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] i_raddr1,
    input  logic [ADDR_W-1:0] i_raddr2,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic              i_wen,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata1,
    output logic [DATA_W-1:0] o_rdata2
);

    logic [DATA_W-1:0] r_mem [NREG];
    logic              w_we;

    assign w_we = i_wen && (i_waddr != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Reads see the pre-edge contents; a same-cycle write shows up next cycle.
    assign o_rdata1 = (i_raddr1 == '0) ? '0 : r_mem[i_raddr1];
    assign o_rdata2 = (i_raddr2 == '0) ? '0 : r_mem[i_raddr2];

endmodule

// File: rtl/dedicated_datapath.sv
// Accumulator datapath: register file, adder, write mux, limit
// comparator, output buffer and sticky overflow/valid flags.
module dedicated_datapath
    import dp_pkg::*;
#(
    parameter int DATA_W = DP_DATA_W,
    parameter int LIMIT  = DP_LIMIT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 MuxSel,
    input  logic [DP_ADDR_W-1:0] raddr1,
    input  logic [DP_ADDR_W-1:0] raddr2,
    input  logic [DP_ADDR_W-1:0] waddr,
    input  logic                 wEn,
    input  logic                 outBuf,
    output logic                 le,
    output logic [DATA_W-1:0]    outPort,
    output logic                 outValid,
    output logic                 ovf
);

    localparam logic [31:0] LIMIT_U = 32'(LIMIT);

    logic [DATA_W-1:0] w_rdata1;
    logic [DATA_W-1:0] w_rdata2;
    logic [DATA_W:0]   w_sum_full;
    logic [DATA_W-1:0] w_wdata;
    logic              w_ovf_hit;
    wsel_e             w_sel;

    logic [DATA_W-1:0] r_out;
    logic              r_valid;
    logic              r_ovf;

    register_file #(
        .DATA_W (DATA_W),
        .ADDR_W (DP_ADDR_W),
        .NREG   (DP_NREG)
    ) u_rf (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_raddr1 (raddr1),
        .i_raddr2 (raddr2),
        .i_waddr  (waddr),
        .i_wen    (wEn),
        .i_wdata  (w_wdata),
        .o_rdata1 (w_rdata1),
        .o_rdata2 (w_rdata2)
    );

    assign w_sel      = wsel_e'(MuxSel);
    assign w_sum_full = {1'b0, w_rdata1} + {1'b0, w_rdata2};
    assign w_wdata    = (w_sel == WSEL_ONE) ? DATA_W'(1)
                                            : w_sum_full[DATA_W-1:0];

    // Only a committed adder write to a real register can flag overflow.
    assign w_ovf_hit = wEn && (w_sel == WSEL_SUM) && (waddr != '0)
                       && w_sum_full[DATA_W];

    assign le = le_bound(32'(w_rdata1), LIMIT_U);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out   <= '0;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            if (outBuf) begin
                r_out   <= w_rdata2;
                r_valid <= 1'b1;
            end
            if (w_ovf_hit) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign outPort  = r_out;
    assign outValid = r_valid;
    assign ovf      = r_ovf;

endmodule

// File: tb/tb_dedicated_datapath.sv
// Scoreboard bench for dedicated_datapath: directed, random and closed-loop
// accumulation stimulus checked against an arithmetic register-file model.
module tb_dedicated_datapath;
    import dp_pkg::*;

    localparam int W   = 8;
    localparam int LIM = 10;
    localparam int MOD = 1 << W;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         MuxSel = 1'b0;
    logic [3:0]   raddr1 = 4'd5;
    logic [3:0]   raddr2 = 4'd0;
    logic [3:0]   waddr = 4'd0;
    logic         wEn = 1'b0;
    logic         outBuf = 1'b0;
    logic         le;
    logic [W-1:0] outPort;
    logic         outValid;
    logic         ovf;

    dedicated_datapath #(.DATA_W(W), .LIMIT(LIM)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .MuxSel   (MuxSel),
        .raddr1   (raddr1),
        .raddr2   (raddr2),
        .waddr    (waddr),
        .wEn      (wEn),
        .outBuf   (outBuf),
        .le       (le),
        .outPort  (outPort),
        .outValid (outValid),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int    port;
        bit    le;
        bit    ovf;
        string tag;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad = 0;

    int unsigned mreg[16];
    bit          movf;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mreg[i] = 0;
        movf = 1'b0;
    endtask

    // One control word for one clock; entered and left at posedge+2.
    task automatic cyc(input bit ms, input int a1, input int a2,
                       input int wa, input bit we, input bit ob,
                       input string tag);
        int unsigned rd1, rd2, sum;
        MuxSel = ms;
        raddr1 = 4'(a1);
        raddr2 = 4'(a2);
        waddr  = 4'(wa);
        wEn    = we;
        outBuf = ob;
        rd1 = mreg[a1];
        rd2 = mreg[a2];
        sum = rd1 + rd2;
        if (we && wa != 0) begin
            mreg[wa] = ms ? 1 : sum % MOD;
            if (!ms && sum >= MOD) movf = 1'b1;
        end
        if (ob) q.push_back('{int'(rd2), rd1 <= LIM, movf, tag});
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, "");
    endtask

    // Controller: R1 counts 1.., R3 holds the increment, R2 accumulates.
    task automatic run_loop(input int stop_at);
        int it;
        cyc(1, 0, 0, 1, 1, 0, "");
        cyc(1, 0, 0, 3, 1, 0, "");
        for (it = 0; it < 20; it++) begin
            if (it == stop_at) return;
            MuxSel = 0; raddr1 = 4'd1; raddr2 = 4'd2;
            waddr = 4'd2; wEn = 0; outBuf = 0;
            #1;
            check("loop.le", int'(le), int'(mreg[1] <= LIM));
            if (!le) break;
            cyc(0, 1, 2, 2, 1, 0, "");
            cyc(0, 1, 3, 1, 1, 0, "");
        end
        if (it == 20) check("loop.timeout", it, 0);
        cyc(0, 0, 2, 0, 0, 1, "loop.sum");
        check("loop.model55", int'(mreg[2]), 55);
    endtask

    // Monitor: whenever the buffer is strobed, compare what it presents.
    initial begin
        exp_t e;
        bit   le_s;
        forever begin
            @(negedge clk);
            if (rst_n && outBuf === 1'b1) begin
                le_s = le;
                @(posedge clk);
                #1;
                if (q.size() == 0) begin
                    check("spurious", 1, 0);
                end else begin
                    e = q.pop_front();
                    check({e.tag, ".port"}, int'(outPort), e.port);
                    check({e.tag, ".le"}, int'(le_s), int'(e.le));
                    check({e.tag, ".ovf"}, int'(ovf), int'(e.ovf));
                    check({e.tag, ".valid"}, int'(outValid), 1);
                end
            end
        end
    end

    initial begin
        model_reset();
        #12;
        check("rst.rdata_le", int'(le), 1);
        check("rst.port", int'(outPort), 0);
        check("rst.valid", int'(outValid), 0);
        check("rst.ovf", int'(ovf), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        cyc(0, 5, 0, 0, 0, 1, "probe");

        cyc(1, 0, 0, 1, 1, 0, "");
        cyc(0, 1, 1, 2, 1, 0, "");
        cyc(0, 2, 2, 0, 0, 1, "r2eq2");

        cyc(0, 2, 2, 2, 1, 0, "");
        cyc(0, 2, 2, 2, 1, 0, "");
        cyc(0, 2, 1, 2, 1, 0, "");
        cyc(0, 2, 1, 2, 1, 0, "");
        cyc(0, 2, 2, 0, 0, 1, "le_at10");
        cyc(0, 2, 1, 2, 1, 0, "");
        cyc(0, 2, 2, 0, 0, 1, "le_at11");

        cyc(0, 1, 1, 4, 1, 0, "");
        cyc(0, 4, 4, 4, 1, 0, "");
        cyc(0, 4, 1, 4, 1, 0, "");
        cyc(0, 4, 0, 0, 1, 0, "");
        cyc(0, 0, 0, 0, 0, 1, "r0_zero");

        cyc(1, 0, 5, 5, 1, 1, "wr_and_buf");
        cyc(0, 0, 5, 0, 0, 1, "r5_new");

        for (int i = 0; i < 7; i++) cyc(0, 1, 1, 1, 1, 0, "");
        cyc(0, 1, 0, 2, 1, 0, "");
        cyc(0, 1, 2, 3, 1, 0, "");
        repeat (3) idle();
        cyc(0, 0, 3, 0, 0, 1, "ovf_sticky");

        repeat (150) begin
            cyc($urandom_range(0, 1), $urandom_range(0, 15),
                $urandom_range(0, 15), $urandom_range(0, 15),
                $urandom_range(0, 1), $urandom_range(0, 2) == 0, "rand");
        end

        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #2;
        run_loop(-1);

        run_loop(4);
        MuxSel = 1; waddr = 4'd2; wEn = 1; raddr1 = 4'd2; outBuf = 0;
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst.port", int'(outPort), 0);
        check("midrst.valid", int'(outValid), 0);
        check("midrst.ovf", int'(ovf), 0);
        check("midrst.le", int'(le), 1);
        wEn = 0; MuxSel = 0;
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #2;
        cyc(0, 0, 1, 0, 0, 1, "midrst.r1");
        cyc(0, 0, 2, 0, 0, 1, "midrst.r2");
        cyc(0, 0, 3, 0, 0, 1, "midrst.r3");
        run_loop(-1);

        repeat (3) idle();
        check("drain", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
